// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EX/MEM/WB sequencer with
// combinational strobe/select decode and an optional memory-wait watchdog.
// Optional feature macro: MC_CTRL_WAIT_TIMEOUT_EN (enables wait timeout).
module mc_ctrl #(
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemRead,
  output logic [1:0]         EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               timeout
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

`ifdef MC_CTRL_WAIT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR
  } kind_t;

  state_t           st_q, st_d, cur;
  logic [CNT_W-1:0] wait_q, wait_d;
  kind_t            kind;
  logic [3:0]       dec_alu;
  logic [1:0]       dec_ext;
  logic             dec_srca;
  logic             waiting, to_hit;

  assign state = st_q;

  // Instruction decode: classify opcode/funct and pick ALU controls
  always_comb begin
    kind     = K_ILL;
    dec_alu  = 4'd0;
    dec_ext  = 2'b00;
    dec_srca = 1'b0;
    case (Op)
      6'h00: begin
        case (Funct)
          6'h20, 6'h21: begin kind = K_RALU; dec_alu = 4'd1; end
          6'h22, 6'h23: begin kind = K_RALU; dec_alu = 4'd2; end
          6'h24:        begin kind = K_RALU; dec_alu = 4'd3; end
          6'h25:        begin kind = K_RALU; dec_alu = 4'd4; end
          6'h2A:        begin kind = K_RALU; dec_alu = 4'd5; end
          6'h2B:        begin kind = K_RALU; dec_alu = 4'd6; end
          6'h00:        begin kind = K_RALU; dec_alu = 4'd7; dec_srca = 1'b1; end
          6'h02:        begin kind = K_RALU; dec_alu = 4'd8; dec_srca = 1'b1; end
          6'h08:        kind = K_JR;
          default:      kind = K_ILL;
        endcase
      end
      6'h08: begin kind = K_IALU; dec_alu = 4'd1; dec_ext = 2'b01; end
      6'h0D: begin kind = K_IALU; dec_alu = 4'd4; dec_ext = 2'b00; end
      6'h0C: begin kind = K_IALU; dec_alu = 4'd3; dec_ext = 2'b00; end
      6'h0F: begin kind = K_IALU; dec_alu = 4'd9; dec_ext = 2'b10; end
      6'h23: begin kind = K_LW;   dec_alu = 4'd1; dec_ext = 2'b01; end
      6'h2B: begin kind = K_SW;   dec_alu = 4'd1; dec_ext = 2'b01; end
      6'h04: begin kind = K_BEQ;  dec_alu = 4'd2; dec_ext = 2'b01; end
      6'h05: begin kind = K_BNE;  dec_alu = 4'd2; dec_ext = 2'b01; end
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      default: kind = K_ILL;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= S_IF;
      wait_q <= '0;
    end else begin
      st_q   <= st_d;
      wait_q <= wait_d;
    end
  end

  // Next-state, strobes and selects; unreachable encodings behave as IF
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    EXTOp    = 2'b00;
    ALUOp    = '0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    NPCOp    = 2'b00;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    illegal  = 1'b0;
    timeout  = 1'b0;
    cur      = (st_q inside {S_IF, S_ID, S_EX, S_MEM, S_WB}) ? st_q : S_IF;
    st_d     = cur;
    waiting  = ((cur == S_IF) || (cur == S_MEM)) && !mem_ready;
    to_hit   = TIMEOUT_EN && waiting && (wait_q == WAIT_LAST);

    case (cur)
      S_IF: begin
        MemRead = 1'b1;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (mem_ready) st_d = S_ID;
      end
      S_ID: begin
        st_d = S_IF;
        case (kind)
          K_J:   begin PCWrite = 1'b1; NPCOp = 2'b10; end
          K_JAL: begin
            PCWrite  = 1'b1;
            NPCOp    = 2'b10;
            RegWrite = 1'b1;
            GPRSel   = 2'b10;
            WDSel    = 2'b10;
          end
          K_JR:  begin PCWrite = 1'b1; NPCOp = 2'b11; end
          K_ILL: illegal = 1'b1;
          default: st_d = S_EX;
        endcase
      end
      S_EX: begin
        ALUOp   = ALUOP_W'(dec_alu);
        EXTOp   = dec_ext;
        ALUSrcA = dec_srca;
        ALUSrcB = (kind == K_RALU) ? 2'b00 : 2'b01;
        case (kind)
          K_BEQ, K_BNE: begin
            ALUSrcB = 2'b00;
            NPCOp   = 2'b01;
            PCWrite = (kind == K_BEQ) ? Zero : !Zero;
            st_d    = S_IF;
          end
          K_LW, K_SW: st_d = S_MEM;
          default:    st_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (kind == K_LW) begin
          MemRead = 1'b1;
          if (mem_ready) st_d = S_WB;
        end else if (kind == K_SW) begin
          MemWrite = 1'b1;
          if (mem_ready) st_d = S_IF;
        end else begin
          st_d = S_IF;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        st_d     = S_IF;
        if (kind == K_LW) begin
          WDSel  = 2'b01;
          GPRSel = 2'b01;
        end else if (kind == K_IALU) begin
          GPRSel = 2'b01;
        end
      end
      default: st_d = S_IF;
    endcase

    // Watchdog expiry abandons the access and refetches
    if (to_hit) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      timeout  = 1'b1;
      st_d     = S_IF;
    end

    wait_d = (TIMEOUT_EN && waiting && !to_hit && (st_d == cur)) ? wait_q + CNT_W'(1) : '0;

    // Reset silences every strobe and pulse immediately
    if (!rstn) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      illegal  = 1'b0;
      timeout  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (default parameters).
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead;
  logic [1:0] EXTOp, ALUSrcB, NPCOp, GPRSel, WDSel;
  logic [3:0] ALUOp;
  logic       ALUSrcA;
  logic [2:0] state;
  logic       illegal, timeout;

  int checks = 0;
  int errors = 0;

  mc_ctrl #(.ALUOP_W(4), .WAIT_MAX(15)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .state(state),
    .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; outputs are checked 1ns later
  task automatic nx;
    @(negedge clk);
  endtask

  // Write strobes packed as {PCWrite,IRWrite,RegWrite,MemWrite,MemRead}
  function automatic logic [4:0] strb();
    return {PCWrite, IRWrite, RegWrite, MemWrite, MemRead};
  endfunction

  initial begin
    rstn = 1'b0; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b1;
    nx; #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(strb()), 32'd0);
    chk("rst_pulses", 32'({illegal, timeout}), 32'd0);
    nx; #1;
    chk("rst_hold_strobes", 32'(strb()), 32'd0);

    // addi: IF ID EX WB
    rstn = 1'b1; Op = 6'h08; #1;
    chk("addi_if_state", 32'(state), 32'd0);
    chk("addi_if_strobes", 32'(strb()), 32'b11001);
    nx; #1;
    chk("addi_id_state", 32'(state), 32'd1);
    chk("addi_id_strobes", 32'(strb()), 32'd0);
    nx; #1;
    chk("addi_ex_state", 32'(state), 32'd2);
    chk("addi_ex_aluop", 32'(ALUOp), 32'd1);
    chk("addi_ex_ext", 32'(EXTOp), 32'd1);
    chk("addi_ex_srcb", 32'(ALUSrcB), 32'd1);
    chk("addi_ex_strobes", 32'(strb()), 32'd0);
    nx; #1;
    chk("addi_wb_state", 32'(state), 32'd4);
    chk("addi_wb_strobes", 32'(strb()), 32'b00100);
    chk("addi_wb_gprsel", 32'(GPRSel), 32'd1);
    chk("addi_wb_wdsel", 32'(WDSel), 32'd0);

    // lw: IF ID EX MEM WB
    nx; Op = 6'h23; #1;
    chk("lw_if_state", 32'(state), 32'd0);
    nx; #1;
    chk("lw_id_state", 32'(state), 32'd1);
    nx; #1;
    chk("lw_ex_state", 32'(state), 32'd2);
    chk("lw_ex_aluop", 32'(ALUOp), 32'd1);
    chk("lw_ex_ext", 32'(EXTOp), 32'd1);
    nx; #1;
    chk("lw_mem_state", 32'(state), 32'd3);
    chk("lw_mem_strobes", 32'(strb()), 32'b00001);
    nx; #1;
    chk("lw_wb_state", 32'(state), 32'd4);
    chk("lw_wb_strobes", 32'(strb()), 32'b00100);
    chk("lw_wb_wdsel", 32'(WDSel), 32'd1);
    chk("lw_wb_gprsel", 32'(GPRSel), 32'd1);

    // beq taken
    nx; Op = 6'h04; Zero = 1'b1; #1;
    chk("beq_if_state", 32'(state), 32'd0);
    nx; nx; #1;
    chk("beq_ex_state", 32'(state), 32'd2);
    chk("beq_ex_pcwrite", 32'(PCWrite), 32'd1);
    chk("beq_ex_npcop", 32'(NPCOp), 32'd1);
    chk("beq_ex_aluop", 32'(ALUOp), 32'd2);
    chk("beq_ex_srcb", 32'(ALUSrcB), 32'd0);

    // bne with Zero=1 is not taken
    nx; Op = 6'h05; #1;
    chk("bne_if_state", 32'(state), 32'd0);
    nx; nx; #1;
    chk("bne_ex_state", 32'(state), 32'd2);
    chk("bne_ex_pcwrite", 32'(PCWrite), 32'd0);
    nx; Zero = 1'b0; #1;
    chk("bne_back_if", 32'(state), 32'd0);

    // jal
    Op = 6'h03; nx; #1;
    chk("jal_id_state", 32'(state), 32'd1);
    chk("jal_id_strobes", 32'(strb()), 32'b10100);
    chk("jal_id_npcop", 32'(NPCOp), 32'd2);
    chk("jal_id_gprsel", 32'(GPRSel), 32'd2);
    chk("jal_id_wdsel", 32'(WDSel), 32'd2);
    nx; #1;
    chk("jal_next_if", 32'(state), 32'd0);

    // jr
    Op = 6'h00; Funct = 6'h08; nx; #1;
    chk("jr_id_strobes", 32'(strb()), 32'b10000);
    chk("jr_id_npcop", 32'(NPCOp), 32'd3);

    // illegal opcode 0x3F
    nx; Op = 6'h3F; #1;
    chk("ill_if_pulse", 32'(illegal), 32'd0);
    nx; #1;
    chk("ill_id_pulse", 32'(illegal), 32'd1);
    chk("ill_id_strobes", 32'(strb()), 32'd0);
    nx; #1;
    chk("ill_back_if", 32'(state), 32'd0);
    chk("ill_pulse_gone", 32'(illegal), 32'd0);

    // sll: shamt source, R-type destination
    Op = 6'h00; Funct = 6'h00; nx; nx; #1;
    chk("sll_ex_aluop", 32'(ALUOp), 32'd7);
    chk("sll_ex_srca", 32'(ALUSrcA), 32'd1);
    chk("sll_ex_srcb", 32'(ALUSrcB), 32'd0);
    nx; #1;
    chk("sll_wb_gprsel", 32'(GPRSel), 32'd0);
    chk("sll_wb_regwrite", 32'(RegWrite), 32'd1);

    // lui
    nx; Op = 6'h0F; #1;
    nx; nx; #1;
    chk("lui_ex_aluop", 32'(ALUOp), 32'd9);
    chk("lui_ex_ext", 32'(EXTOp), 32'd2);

    // IF stalls while memory is not ready
    nx; nx; mem_ready = 1'b0; #1;
    chk("ifwait_state", 32'(state), 32'd0);
    chk("ifwait_strobes", 32'(strb()), 32'b00001);
    nx; #1;
    chk("ifwait_hold", 32'(state), 32'd0);

    // sw with a long MEM wait
    mem_ready = 1'b1; Op = 6'h2B; Funct = 6'h00; nx; nx; nx; mem_ready = 1'b0; #1;
    chk("sw_mem_state", 32'(state), 32'd3);
    chk("sw_mem_strobes", 32'(strb()), 32'b00010);
    for (int i = 2; i <= 14; i++) nx;
    #1;
    chk("sw_wait14_timeout", 32'(timeout), 32'd0);
    nx; #1;
`ifdef MC_CTRL_WAIT_TIMEOUT_EN
    chk("sw_wait15_timeout", 32'(timeout), 32'd1);
    chk("sw_wait15_memwrite", 32'(MemWrite), 32'd0);
    nx; #1;
    chk("sw_to_state", 32'(state), 32'd0);
    chk("sw_to_pulse_gone", 32'(timeout), 32'd0);
    mem_ready = 1'b1; #1;
`else
    chk("sw_wait15_timeout", 32'(timeout), 32'd0);
    chk("sw_wait15_memwrite", 32'(MemWrite), 32'd1);
    nx; #1;
    chk("sw_wait16_state", 32'(state), 32'd3);
    mem_ready = 1'b1; #1;
    chk("sw_done_memwrite", 32'(MemWrite), 32'd1);
    nx; #1;
`endif
    chk("sw_end_state", 32'(state), 32'd0);

    // lw interrupted by reset in WB
    Op = 6'h23; nx; nx; nx; nx; #1;
    chk("rlw_wb_state", 32'(state), 32'd4);
    chk("rlw_wb_regwrite", 32'(RegWrite), 32'd1);
    #1 rstn = 1'b0; #1;
    chk("rlw_async_regwrite", 32'(RegWrite), 32'd0);
    chk("rlw_async_state", 32'(state), 32'd0);
    nx; #1;
    chk("rlw_hold_strobes", 32'(strb()), 32'd0);
    rstn = 1'b1; Op = 6'h08; #1;
    chk("rlw_resume_strobes", 32'(strb()), 32'b11001);
    nx; #1;
    chk("rlw_resume_id", 32'(state), 32'd1);
    chk("rlw_resume_id_strobes", 32'(strb()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
